pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (in, 1), rst_n (in, 1).
REQ-002 The block SHALL have ic_read (in, 1): I-cache line read request.
REQ-003 The block SHALL have ic_address (in, 32): I-cache line address.
REQ-004 The block SHALL have ic_rdata (out, 256): I-cache read line.
REQ-005 The block SHALL have ic_resp (out, 1): I-cache done pulse.
REQ-006 The block SHALL have dc_read and dc_write (in, 1 each): D-cache line requests.
REQ-007 The block SHALL have dc_address (in, 32) and dc_wdata (in, 256): D-cache request address and write line.
REQ-008 The block SHALL have dc_rdata (out, 256) and dc_resp (out, 1): D-cache read line and done pulse.
REQ-009 The block SHALL have pmem_read and pmem_write (out, 1 each), pmem_address (out, 32) and pmem_wdata (out, 256): physical memory request.
REQ-010 The block SHALL have pmem_resp (in, 1) and pmem_rdata (in, 256): physical memory completion and read line.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-012 In IDLE, a request SHALL move the FSM at the next edge:
- ic_read only -> SERVE_I.
- dc_read or dc_write only -> SERVE_D.
- both pending -> the requester not recorded in last_served.
REQ-013 last_served SHALL update on every grant; its reset value SHALL be I, so the D-cache wins the first tie.
REQ-014 On the grant edge the block SHALL latch the served address, the write line and op into registers.
- Op is write if dc_write is asserted, else read.
- dc_read and dc_write together SHALL be treated as write.
REQ-015 pmem_address and pmem_wdata SHALL be driven only from the latched registers, never from live requester inputs.
REQ-016 pmem_read/pmem_write SHALL be asserted throughout SERVE_x per the latched op, and SHALL be 0 in IDLE.
- Minimum latency: request seen in IDLE at cycle N -> pmem command from cycle N+1.
REQ-017 In SERVE_I, pmem_resp=1 SHALL:
- assert ic_resp combinationally in the same cycle;
- route pmem_rdata to ic_rdata;
- return the FSM to IDLE at the next edge.
REQ-018 SERVE_D SHALL behave as REQ-017 with dc_resp and dc_rdata.
REQ-019 The ic_rdata and dc_rdata data paths SHALL both be wired to pmem_rdata continuously; only the resp flags are steered.
REQ-020 Exactly one transaction SHALL be outstanding at a time.
- Requests arriving during SERVE_x SHALL wait until IDLE.
- pmem_resp in IDLE SHALL be ignored: no resp to either requester.
REQ-021 A requester dropping its request mid-service SHALL NOT abort the transaction.
- pmem commands are not abortable; the FSM holds until pmem_resp.
- The resp pulse SHALL still be issued.
REQ-022 IDLE SHALL be entered for at least one cycle between transactions.
- Back-to-back grants: pmem_resp at cycle M -> next pmem command no earlier than M+2.
REQ-023 ic_resp and dc_resp SHALL never be asserted in the same cycle.
REQ-024 ic_resp and dc_resp SHALL each be asserted for one cycle per pmem_resp.

Reset
REQ-025 While rst_n=0, outputs SHALL be forced asynchronously:
- state=IDLE, last_served=I;
- pmem_read=0, pmem_write=0;
- ic_resp=0, dc_resp=0;
- pmem_address and latched wdata = 0.
REQ-026 Reset asserted during SERVE_x SHALL drop pmem_read/pmem_write immediately.
- No resp SHALL be issued for the aborted transaction.
- Operation SHALL resume from IDLE on the first edge after rst_n rises.

Verification
REQ-027 Single I-read test: ic_read, ic_address=0x0000_0060, pmem_resp 5 cycles later with rdata=0xA5 repeated.
- pmem_read=1 with address 0x60 from the next cycle.
- ic_resp pulses once with ic_rdata=0xA5 pattern; dc_resp stays 0.
REQ-028 D-write test: dc_write, dc_address=0x0000_1000, dc_wdata=0x1234 pattern.
- pmem_write=1, pmem_address=0x1000, pmem_wdata=0x1234 pattern.
- Changing dc_wdata mid-service leaves pmem_wdata unchanged; dc_resp pulses once.
REQ-029 Simultaneous-request test: ic_read and dc_read both held from reset.
- Grant order is D, I, D, I.
- Each gap from pmem_resp to the next command is ≥2 cycles.
REQ-030 Reset-abort test: rst_n pulled low 2 cycles into SERVE_I.
- pmem_read falls the same cycle; no ic_resp.
- After release, a held ic_read is re-granted.
REQ-031 Spurious-resp test: pmem_resp=1 in IDLE -> no ic_resp or dc_resp; state remains IDLE.
REQ-032 Dual-op test: dc_read and dc_write both asserted -> pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory line signals.
// The master view belongs to the arbiter; the slave view belongs to the caches and the memory.
interface pmem_arbiter_if;
    logic         ic_read;
    logic [31:0]  ic_address;
    logic [255:0] ic_rdata;
    logic         ic_resp;

    logic         dc_read;
    logic         dc_write;
    logic [31:0]  dc_address;
    logic [255:0] dc_wdata;
    logic [255:0] dc_rdata;
    logic         dc_resp;

    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    modport master (
        input  ic_read, ic_address, dc_read, dc_write, dc_address, dc_wdata,
        input  pmem_resp, pmem_rdata,
        output ic_rdata, ic_resp, dc_rdata, dc_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output ic_read, ic_address, dc_read, dc_write, dc_address, dc_wdata,
        output pmem_resp, pmem_rdata,
        input  ic_rdata, ic_resp, dc_rdata, dc_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Two-requester physical-memory arbiter: one outstanding line transaction at a time,
// alternating priority on ties, with the memory command issued from latched registers.
module pmem_arbiter (
    input logic            clk,
    input logic            rst_n,
    pmem_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

    state_e         state_q;
    logic           last_d_q;
    logic [31:0]    addr_q;
    logic [255:0]   wdata_q;
    logic           read_q;
    logic           write_q;

    logic dc_req;
    logic grant_d;

    assign dc_req  = bus.dc_read | bus.dc_write;
    // On a tie, the side that was not served last wins.
    assign grant_d = dc_req & (~bus.ic_read | ~last_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.ic_read || dc_req) begin
                        addr_q   <= grant_d ? bus.dc_address : bus.ic_address;
                        if (grant_d) begin
                            wdata_q <= bus.dc_wdata;
                        end
                        read_q   <= ~(grant_d & bus.dc_write);
                        write_q  <= grant_d & bus.dc_write;
                        last_d_q <= grant_d;
                        state_q  <= grant_d ? StServeD : StServeI;
                    end
                end
                StServeI, StServeD: begin
                    if (bus.pmem_resp) begin
                        state_q <= StIdle;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_read    = read_q;
    assign bus.pmem_write   = write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    // Data is wired straight through; only the completion flags are steered.
    assign bus.ic_rdata = bus.pmem_rdata;
    assign bus.dc_rdata = bus.pmem_rdata;
    assign bus.ic_resp  = (state_q == StServeI) & bus.pmem_resp;
    assign bus.dc_resp  = (state_q == StServeD) & bus.pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: expected transactions are queued as requests are raised
// and checked against the memory command and the requester completion.
module tb_pmem_arbiter;

    logic clk;
    logic rst_n;
    pmem_arbiter_if bus ();

    pmem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wdata);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = addr;
        t.wdata = wdata;
        sb.push_back(t);
    endtask

    task automatic clear_reqs();
        bus.ic_read  = 1'b0;
        bus.dc_read  = 1'b0;
        bus.dc_write = 1'b0;
    endtask

    // Waits (bounded) for a memory command; returns the number of negedges taken, 0 on timeout.
    task automatic wait_cmd(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.pmem_read || bus.pmem_write) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) check("cmd_timeout", 256'(0), 256'(1));
    endtask

    // Serves the oldest queued transaction: checks the command, holds it for delay cycles,
    // returns rdata and checks the completion and the following idle gap.
    task automatic serve(input int delay, input logic drop, input logic [255:0] rdata,
                         input logic [255:0] new_wdata, output int lat);
        txn_t t;
        wait_cmd(lat);
        if (lat == 0) return;
        if (sb.size() == 0) begin
            check("sb_empty", 256'(0), 256'(1));
            return;
        end
        t = sb.pop_front();
        check("pmem_write", 256'(bus.pmem_write), 256'(t.wr));
        check("pmem_read", 256'(bus.pmem_read), 256'(!t.wr));
        check("pmem_address", 256'(bus.pmem_address), 256'(t.addr));
        if (t.wr) check("pmem_wdata", bus.pmem_wdata, t.wdata);
        if (drop) clear_reqs();
        bus.dc_wdata   = new_wdata;
        bus.dc_address = 32'hDEAD_BEE0;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            check("hold_cmd", 256'({bus.pmem_read, bus.pmem_write}), 256'({!t.wr, t.wr}));
            check("hold_addr", 256'(bus.pmem_address), 256'(t.addr));
        end
        if (t.wr) check("hold_wdata", bus.pmem_wdata, t.wdata);
        @(posedge clk);
        #1;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rdata;
        @(negedge clk);
        check("resp_flags", 256'({bus.ic_resp, bus.dc_resp}), 256'({!t.is_d, t.is_d}));
        check("resp_rdata", t.is_d ? bus.dc_rdata : bus.ic_rdata, rdata);
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        check("gap_idle", 256'({bus.pmem_read, bus.pmem_write, bus.ic_resp, bus.dc_resp}), 256'(0));
    endtask

    int lat;

    initial begin
        rst_n          = 1'b0;
        clear_reqs();
        bus.ic_address = '0;
        bus.dc_address = '0;
        bus.dc_wdata   = '0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 256'({bus.pmem_read, bus.pmem_write, bus.ic_resp, bus.dc_resp}), 256'(0));
        check("rst_address", 256'(bus.pmem_address), 256'(0));
        check("rst_wdata", bus.pmem_wdata, 256'(0));
        rst_n = 1'b1;

        // Single I-cache read.
        @(posedge clk);
        #1;
        bus.ic_read    = 1'b1;
        bus.ic_address = 32'h0000_0060;
        push(1'b0, 1'b0, 32'h0000_0060, '0);
        serve(5, 1'b1, {32{8'hA5}}, '0, lat);
        check("i_latency", 256'(lat), 256'(2));

        // D-cache write; wdata and address change mid-service.
        @(posedge clk);
        #1;
        bus.dc_write   = 1'b1;
        bus.dc_address = 32'h0000_1000;
        bus.dc_wdata   = {16{16'h1234}};
        push(1'b1, 1'b1, 32'h0000_1000, {16{16'h1234}});
        serve(4, 1'b1, {8{32'h0BAD_F00D}}, {16{16'hFFFF}}, lat);
        check("d_latency", 256'(lat), 256'(2));

        // Read and write together count as a write.
        @(posedge clk);
        #1;
        bus.dc_read    = 1'b1;
        bus.dc_write   = 1'b1;
        bus.dc_address = 32'h0000_2040;
        bus.dc_wdata   = {8{32'hC0DE_0001}};
        push(1'b1, 1'b1, 32'h0000_2040, {8{32'hC0DE_0001}});
        serve(3, 1'b1, {8{32'h1111_2222}}, '0, lat);

        // Spurious pmem_resp in IDLE.
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        check("spur_resp", 256'({bus.ic_resp, bus.dc_resp}), 256'(0));
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        check("spur_idle", 256'({bus.pmem_read, bus.pmem_write, bus.ic_resp, bus.dc_resp}), 256'(0));

        // Both requesters held from reset: D wins first, then strict alternation.
        rst_n          = 1'b0;
        bus.ic_read    = 1'b1;
        bus.ic_address = 32'h0000_0200;
        bus.dc_read    = 1'b1;
        bus.dc_address = 32'h0000_0300;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(k % 2 == 0, 1'b0, (k % 2 == 0) ? 32'h0000_0300 : 32'h0000_0200, '0);
            // Restore the address that serve() scribbles over while D is waiting.
            serve(2 + k, k == 3, {8{32'h5A5A_0000 + 32'(k)}}, '0, lat);
            bus.dc_address = 32'h0000_0300;
        end

        // Reset two cycles into SERVE_I drops the command with no completion.
        @(posedge clk);
        #1;
        bus.ic_read    = 1'b1;
        bus.ic_address = 32'h0000_0400;
        wait_cmd(lat);
        repeat (2) @(negedge clk);
        bus.pmem_resp = 1'b1;
        rst_n         = 1'b0;
        #1;
        check("abort_cmd", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
        check("abort_resp", 256'({bus.ic_resp, bus.dc_resp}), 256'(0));
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        rst_n         = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0400, '0);
        serve(2, 1'b1, {8{32'h7777_8888}}, '0, lat);
        check("regrant_latency", 256'(lat), 256'(1));
        check("sb_drained", 256'(sb.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
